// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multi-cycle control FSM and the RV32I datapath /
// unified memory.
//   master : the control FSM (reads opcode/flags, drives strobes and selects)
//   slave  : the datapath side (drives opcode/flags, consumes strobes/selects)
// Signals:
//   opcode_i       instr[6:0] from the instruction register
//   branch_cond_i  ALU compare result, 1 = branch taken
//   mem_ready_i    memory completes the current read/write this cycle
//   mem_read_o / mem_write_o / iord_o      memory request and address select
//   ir_write_o / pc_write_o / reg_write_o  register load strobes
//   alu_src_a_o / alu_src_b_o / alu_op_o / result_src_o  datapath selects
//   instr_done_o / illegal_o               per-instruction status pulses
interface multicycle_control_fsm_if;
   logic [6:0] opcode_i;
   logic       branch_cond_i;
   logic       mem_ready_i;
   logic       mem_read_o;
   logic       mem_write_o;
   logic       iord_o;
   logic       ir_write_o;
   logic       pc_write_o;
   logic       reg_write_o;
   logic [1:0] alu_src_a_o;
   logic [1:0] alu_src_b_o;
   logic [1:0] alu_op_o;
   logic [1:0] result_src_o;
   logic       instr_done_o;
   logic       illegal_o;

   modport master (
      input  opcode_i, branch_cond_i, mem_ready_i,
      output mem_read_o, mem_write_o, iord_o, ir_write_o, pc_write_o,
             reg_write_o, alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o,
             instr_done_o, illegal_o
   );

   modport slave (
      output opcode_i, branch_cond_i, mem_ready_i,
      input  mem_read_o, mem_write_o, iord_o, ir_write_o, pc_write_o,
             reg_write_o, alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o,
             instr_done_o, illegal_o
   );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Control FSM sequencing the RV32I multi-cycle datapath through fetch, decode,
// execute, memory access and write-back.
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset (forces FETCH)
//   bus    control bundle (master side), see multicycle_control_fsm_if
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_FETCH    | read instr at PC, PC <- PC+4 on mem_ready
// S_DECODE   | ALUOut <- oldPC+imm, dispatch on opcode
// S_MEMADR   | ALUOut <- rs1+imm (load/store address)
// S_MEMREAD  | load data read, wait for mem_ready
// S_MEMWB    | rd <- memory data
// S_MEMWRITE | store data write, wait for mem_ready
// S_EXEC_R   | ALUOut <- rs1 op rs2
// S_EXEC_I   | ALUOut <- rs1 op imm
// S_ALUWB    | rd <- ALUOut
// S_BRANCH   | compare rs1/rs2, PC <- ALUOut if taken
// S_JALR     | ALUOut <- rs1+imm (jump target)
// S_JAL      | PC <- ALUOut, ALUOut <- oldPC+4 (link value)
// S_LUI      | ALUOut <- 0+imm
// S_AUIPC    | ALUOut <- oldPC+imm
module multicycle_control_fsm (
   input  logic                       clk,
   input  logic                       rst_n,
   multicycle_control_fsm_if.master   bus
);

   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   localparam logic [1:0] A_PC    = 2'b00;
   localparam logic [1:0] A_OLDPC = 2'b01;
   localparam logic [1:0] A_RS1   = 2'b10;
   localparam logic [1:0] A_ZERO  = 2'b11;
   localparam logic [1:0] B_RS2   = 2'b00;
   localparam logic [1:0] B_IMM   = 2'b01;
   localparam logic [1:0] B_FOUR  = 2'b10;
   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_CMP  = 2'b01;
   localparam logic [1:0] OP_FUNC = 2'b10;
   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_MEM    = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_EXEC_R, S_EXEC_I, S_ALUWB, S_BRANCH, S_JALR, S_JAL, S_LUI, S_AUIPC
   } state_t;

   state_t     state_q, state_d;

   logic       mem_read, mem_write, iord, ir_write, pc_write, reg_write;
   logic [1:0] src_a, src_b, alu_op, result_src;
   logic       instr_done, illegal;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      src_a      = A_PC;
      src_b      = B_RS2;
      alu_op     = OP_ADD;
      result_src = RES_ALUOUT;
      instr_done = 1'b0;
      illegal    = 1'b0;

      unique case (state_q)
         S_FETCH: begin
            mem_read   = 1'b1;
            src_a      = A_PC;
            src_b      = B_FOUR;
            result_src = RES_ALU;
            // The load strobes are held off while reset is asserted so a ready
            // memory cannot clobber IR/PC during reset.
            if (bus.mem_ready_i && rst_n) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end
         end
         S_DECODE: begin
            src_a = A_OLDPC;
            src_b = B_IMM;
            case (bus.opcode_i)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXEC_R;
               OP_I:         state_d = S_EXEC_I;
               OP_BR:        state_d = S_BRANCH;
               OP_JAL:       state_d = S_JAL;
               OP_JALR:      state_d = S_JALR;
               OP_LUI:       state_d = S_LUI;
               OP_AUIPC:     state_d = S_AUIPC;
               default: begin
                  illegal    = 1'b1;
                  instr_done = 1'b1;
                  state_d    = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            src_a   = A_RS1;
            src_b   = B_IMM;
            state_d = (bus.opcode_i == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
            if (bus.mem_ready_i) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            result_src = RES_MEM;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWRITE: begin
            mem_write = 1'b1;
            iord      = 1'b1;
            if (bus.mem_ready_i) begin
               instr_done = 1'b1;
               state_d    = S_FETCH;
            end
         end
         S_EXEC_R: begin
            src_a   = A_RS1;
            src_b   = B_RS2;
            alu_op  = OP_FUNC;
            state_d = S_ALUWB;
         end
         S_EXEC_I: begin
            src_a   = A_RS1;
            src_b   = B_IMM;
            alu_op  = OP_FUNC;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write  = 1'b1;
            result_src = RES_ALUOUT;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_BRANCH: begin
            src_a      = A_RS1;
            src_b      = B_RS2;
            alu_op     = OP_CMP;
            result_src = RES_ALUOUT;
            pc_write   = bus.branch_cond_i;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_JALR: begin
            src_a   = A_RS1;
            src_b   = B_IMM;
            state_d = S_JAL;
         end
         S_JAL: begin
            // PC takes the target already in ALUOut while the ALU computes the
            // link value oldPC+4 into ALUOut for ALUWB.
            src_a      = A_OLDPC;
            src_b      = B_FOUR;
            result_src = RES_ALUOUT;
            pc_write   = 1'b1;
            state_d    = S_ALUWB;
         end
         S_LUI: begin
            src_a   = A_ZERO;
            src_b   = B_IMM;
            state_d = S_ALUWB;
         end
         S_AUIPC: begin
            src_a   = A_OLDPC;
            src_b   = B_IMM;
            state_d = S_ALUWB;
         end
         default: state_d = S_FETCH;
      endcase
   end

   assign bus.mem_read_o   = mem_read;
   assign bus.mem_write_o  = mem_write;
   assign bus.iord_o       = iord;
   assign bus.ir_write_o   = ir_write;
   assign bus.pc_write_o   = pc_write;
   assign bus.reg_write_o  = reg_write;
   assign bus.alu_src_a_o  = src_a;
   assign bus.alu_src_b_o  = src_b;
   assign bus.alu_op_o     = alu_op;
   assign bus.result_src_o = result_src;
   assign bus.instr_done_o = instr_done;
   assign bus.illegal_o    = illegal;

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Moore/Mealy control state machine that sequences the RV32I multi-cycle datapath: instruction fetch, decode, execute, memory access and write-back. It reads the opcode held in the instruction register (the same field the immediate generator decodes) and drives register-enable strobes, mux selects and the memory request for each step. It sits beside the immediate generator, ALU and register file in the core and handshakes with the unified instruction/data memory through `mem_ready_i`.

## Interface
- No parameters. Opcode encodings are fixed RV32I: LW 0000011, SW 0100011, R-type 0110011, I-ALU 0010011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `opcode_i`  in  7  instr[6:0] from the instruction register.
- `branch_cond_i`  in  1  ALU comparison result for the current branch: 1 means taken.
- `mem_ready_i`  in  1  memory completes the current read or write this cycle.
- `mem_read_o`  out  1  memory read request.
- `mem_write_o`  out  1  memory write request.
- `iord_o`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `ir_write_o`  out  1  load the instruction register and old-PC register.
- `pc_write_o`  out  1  load the PC from the result bus.
- `reg_write_o`  out  1  write rd from the result bus.
- `alu_src_a_o`  out  2  ALU A select: 00 = PC, 01 = oldPC, 10 = rs1, 11 = zero.
- `alu_src_b_o`  out  2  ALU B select: 00 = rs2, 01 = imm, 10 = constant 4.
- `alu_op_o`  out  2  ALU operation: 00 = add, 01 = branch compare, 10 = decode funct3/funct7.
- `result_src_o`  out  2  result bus select: 00 = ALUOut register, 01 = memory data, 10 = ALU result.
- `instr_done_o`  out  1  one-cycle pulse on the final cycle of each instruction.
- `illegal_o`  out  1  one-cycle pulse when DECODE sees an unsupported opcode.

## Operation
- **Output defaults:** every state drives all strobes to 0 and all selects to 00 unless the state's entry below says otherwise. Outputs are combinational from the state register, plus `mem_ready_i`/`branch_cond_i` where noted.
- **FETCH:**
  - Drives `mem_read`=1, `iord`=0, A=PC, B=4, op=add, result=10.
  - If `mem_ready_i`: `ir_write`=1 and `pc_write`=1 (PC←PC+4), next state DECODE. Otherwise hold in FETCH.
- **DECODE:**
  - Drives A=oldPC, B=imm, op=add, so ALUOut←branch/JAL target.
  - Next state by opcode: LW/SW→MEMADR, R→EXEC_R, I-ALU→EXEC_I, BRANCH→BRANCH, JAL→JAL, JALR→JALR, LUI→LUI, AUIPC→AUIPC.
  - Any other opcode: `illegal`=1, `instr_done`=1, next state FETCH.
- **MEMADR:** A=rs1, B=imm, op=add. Next state MEMREAD if LW, MEMWRITE if SW.
- **MEMREAD:** `mem_read`=1, `iord`=1. Next state MEMWB when `mem_ready_i`; otherwise hold.
- **MEMWB:** `reg_write`=1, result=01, `instr_done`=1, next state FETCH.
- **MEMWRITE:** `mem_write`=1, `iord`=1. When `mem_ready_i`: `instr_done`=1, next state FETCH; otherwise hold.
- **EXEC_R:** A=rs1, B=rs2, op=10, next state ALUWB.
- **EXEC_I:** A=rs1, B=imm, op=10, next state ALUWB.
- **ALUWB:** `reg_write`=1, result=00, `instr_done`=1, next state FETCH.
- **BRANCH:** A=rs1, B=rs2, op=01, result=00, `pc_write`=`branch_cond_i`, `instr_done`=1, next state FETCH.
- **JALR:** A=rs1, B=imm, op=add (ALUOut←target), next state JAL.
- **JAL:** A=oldPC, B=4, op=add, result=00, `pc_write`=1 (PC←ALUOut target; ALUOut←oldPC+4), next state ALUWB.
- **LUI:** A=zero, B=imm, op=add, next state ALUWB.
- **AUIPC:** A=oldPC, B=imm, op=add, next state ALUWB.
- `opcode_i` is sampled only in DECODE and MEMADR. `mem_ready_i` is ignored outside FETCH, MEMREAD and MEMWRITE. `branch_cond_i` is ignored outside BRANCH.
- A memory request is held asserted with constant `iord` until the `mem_ready_i` cycle. There is no timeout.

## Timing
- **Reset:** asynchronous assert forces state FETCH immediately, including mid-instruction. Reset output values are FETCH's: `mem_read`=1, `alu_src_b`=10, `result_src`=10, all other outputs 0. `ir_write` and `pc_write` also stay 0 while `rst_n`=0.
- **Reset release:** the first fetch request is presented in the first cycle after release.
- **Cycles per instruction with `mem_ready_i` tied high:**
  - BRANCH: 3.
  - R, I-ALU, SW, JAL, LUI, AUIPC: 4.
  - LW, JALR: 5.
  - Illegal opcode: 2.
- **Wait states:** each cycle with `mem_ready_i`=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- **`instr_done_o`:** exactly one pulse per instruction, never asserted in two consecutive cycles.

## Test plan
- **Reset and first fetch:** assert `rst_n`=0 mid-MEMREAD -> same cycle `mem_write`/`reg_write`=0 and `mem_read`=1. After release with `mem_ready_i`=1, `ir_write`=`pc_write`=1 in cycle 1.
- **Zero-wait R-type:** opcode 0110011 -> states FETCH, DECODE, EXEC_R, ALUWB; `reg_write` high only in cycle 4 with `result_src`=00; `instr_done` in cycle 4.
- **LW with 2 wait states in MEMREAD:** -> `mem_read`=1 and `iord`=1 held for 3 cycles; total 7 cycles; `result_src`=01 in MEMWB.
- **BRANCH:** `branch_cond_i`=1 -> `pc_write`=1 in cycle 3. `branch_cond_i`=0 -> `pc_write` stays 0. Next FETCH in cycle 4 in both cases.
- **JALR:** state sequence DECODE→JALR→JAL→ALUWB; `pc_write`=1 in JAL with `result_src`=00; `reg_write` in ALUWB; 5 cycles total.
- **Illegal opcode 1111111:** `illegal_o` and `instr_done_o` both pulse in DECODE (cycle 2); FETCH follows; no `reg_write` or `mem_write` asserted.
